// File: rtl/pciecfg_pkg.sv
// Shared types and constants for the PCIe configuration-access ingress path:
// the FIFO entry layout, wire-format constants and the parser state enum.
package pciecfg_pkg;

  localparam logic [15:0] PCIECFG_UDP_PORT = 16'h3000;
  localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
  localparam logic [7:0]  PCIECFG_OP_RD    = 8'h00;
  localparam logic [7:0]  PCIECFG_OP_WR    = 8'h01;

  typedef struct packed {
    logic        is_write;
    logic [3:0]  be;
    logic [9:0]  pos;
    logic [31:0] data;
    logic [31:0] src_ip;
    logic [15:0] src_port;
  } FIFO_PCIECFG_T;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_DISCARD
  } pciecfg_rx_state_e;

  // Byte idx of a beat; byte 0 is the first on the wire.
  function automatic logic [7:0] byte_at(input logic [63:0] d, input logic [2:0] idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pciecfg_rx_stats.sv
// Frame statistics for pciecfg_rx. Counters exist only when PCIECFG_RX_STATS_EN
// is defined; otherwise every output reads 0.
module pciecfg_rx_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_accept,
  input  logic        inc_drop_full,
  input  logic        inc_drop_bad,
  output logic [31:0] stat_accept,
  output logic [31:0] stat_drop_full,
  output logic [31:0] stat_drop_bad
);

`ifdef PCIECFG_RX_STATS_EN
  logic [31:0] accept_q, accept_d;
  logic [31:0] drop_full_q, drop_full_d;
  logic [31:0] drop_bad_q, drop_bad_d;

  // Plain wrapping counters.
  always_comb begin
    accept_d    = accept_q + 32'(inc_accept);
    drop_full_d = drop_full_q + 32'(inc_drop_full);
    drop_bad_d  = drop_bad_q + 32'(inc_drop_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_q    <= '0;
      drop_full_q <= '0;
      drop_bad_q  <= '0;
    end else begin
      accept_q    <= accept_d;
      drop_full_q <= drop_full_d;
      drop_bad_q  <= drop_bad_d;
    end
  end

  assign stat_accept    = accept_q;
  assign stat_drop_full = drop_full_q;
  assign stat_drop_bad  = drop_bad_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{clk, rst, inc_accept, inc_drop_full, inc_drop_bad};
  assign stat_accept    = '0;
  assign stat_drop_full = '0;
  assign stat_drop_bad  = '0;
`endif

endmodule

// File: rtl/pciecfg_rx.sv
// Ethernet/IPv4/UDP ingress parser that turns configuration-port frames into
// pciecfg FIFO entries. Statistics counters depend on PCIECFG_RX_STATS_EN.
module pciecfg_rx
  import pciecfg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       local_ip,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tkeep,
  input  logic              s_axis_tlast,
  output logic              fifo_pciecfg_i_wr_en,
  input  logic              fifo_pciecfg_i_full,
  output FIFO_PCIECFG_T     fifo_pciecfg_i_din,
  output logic [31:0]       stat_accept,
  output logic [31:0]       stat_drop_full,
  output logic [31:0]       stat_drop_bad,
  output pciecfg_rx_state_e dbg_state
);

  // Stream handshake: a beat transfers on every cycle with tvalid=1, since
  // tready is tied high; tvalid=0 cycles leave all parser state untouched.
  assign s_axis_tready = 1'b1;

  pciecfg_rx_state_e state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [31:0]       src_ip_q, src_ip_d;
  logic [15:0]       src_port_q, src_port_d;
  logic              is_write_q, is_write_d;
  logic [3:0]        be_q, be_d;
  logic [9:0]        pos_q, pos_d;
  logic [15:0]       data_hi_q, data_hi_d;
  logic              wr_en_q, wr_en_d;
  FIFO_PCIECFG_T     din_q, din_d;

  logic          hdr_match;
  logic          pay_ok;
  logic          inc_accept, inc_drop_full, inc_drop_bad;
  FIFO_PCIECFG_T entry;

  logic unused_keep;
  assign unused_keep = ^s_axis_tkeep[7:2];

  // Header field check for the beat currently on the bus.
  always_comb begin
    hdr_match = 1'b1;
    case (beat_q)
      3'd1: hdr_match = ({byte_at(s_axis_tdata, 3'd4), byte_at(s_axis_tdata, 3'd5)} == ETHERTYPE_IPV4)
                     && (byte_at(s_axis_tdata, 3'd6) == IPV4_VER_IHL);
      3'd2: hdr_match = (byte_at(s_axis_tdata, 3'd7) == IP_PROTO_UDP);
      3'd3: hdr_match = ({byte_at(s_axis_tdata, 3'd6), byte_at(s_axis_tdata, 3'd7)} == local_ip[31:16]);
      3'd4: hdr_match = ({byte_at(s_axis_tdata, 3'd0), byte_at(s_axis_tdata, 3'd1)} == local_ip[15:0])
                     && ({byte_at(s_axis_tdata, 3'd4), byte_at(s_axis_tdata, 3'd5)} == PCIECFG_UDP_PORT);
      default: hdr_match = 1'b1;
    endcase
  end

  // Opcode and address-range check, meaningful on beat 5.
  assign pay_ok = ((byte_at(s_axis_tdata, 3'd2) == PCIECFG_OP_RD) ||
                   (byte_at(s_axis_tdata, 3'd2) == PCIECFG_OP_WR))
                && (byte_at(s_axis_tdata, 3'd4)[7:4] == 4'h0);

  always_comb begin
    entry          = '0;
    entry.is_write = is_write_q;
    entry.be       = be_q;
    entry.pos      = pos_q;
    entry.data     = is_write_q ? {data_hi_q, byte_at(s_axis_tdata, 3'd0), byte_at(s_axis_tdata, 3'd1)}
                                : 32'h0;
    entry.src_ip   = src_ip_q;
    entry.src_port = src_port_q;
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    src_ip_d      = src_ip_q;
    src_port_d    = src_port_q;
    is_write_d    = is_write_q;
    be_d          = be_q;
    pos_d         = pos_q;
    data_hi_d     = data_hi_q;
    wr_en_d       = 1'b0;
    din_d         = din_q;
    inc_accept    = 1'b0;
    inc_drop_full = 1'b0;
    inc_drop_bad  = 1'b0;

    if (s_axis_tvalid) begin
      if (s_axis_tlast)         beat_d = 3'd0;
      else if (beat_q != 3'd7)  beat_d = beat_q + 3'd1;

      case (state_q)
        ST_IDLE: begin
          if (!s_axis_tlast) state_d = ST_HDR;
        end
        ST_HDR: begin
          case (beat_q)
            3'd3: src_ip_d = {byte_at(s_axis_tdata, 3'd2), byte_at(s_axis_tdata, 3'd3),
                              byte_at(s_axis_tdata, 3'd4), byte_at(s_axis_tdata, 3'd5)};
            3'd4: src_port_d = {byte_at(s_axis_tdata, 3'd2), byte_at(s_axis_tdata, 3'd3)};
            3'd5: begin
              is_write_d = (byte_at(s_axis_tdata, 3'd2) == PCIECFG_OP_WR);
              be_d       = byte_at(s_axis_tdata, 3'd3)[3:0];
              pos_d      = {byte_at(s_axis_tdata, 3'd4)[3:0], byte_at(s_axis_tdata, 3'd5)[7:2]};
              data_hi_d  = {byte_at(s_axis_tdata, 3'd6), byte_at(s_axis_tdata, 3'd7)};
            end
            default: ;
          endcase

          // Header mismatches are silent; once the port has matched on
          // beat 4, any later problem is a malformed request.
          if (!hdr_match) begin
            state_d = s_axis_tlast ? ST_IDLE : ST_DISCARD;
          end else if (beat_q == 3'd5) begin
            if (!pay_ok || s_axis_tlast) begin
              inc_drop_bad = 1'b1;
              state_d      = s_axis_tlast ? ST_IDLE : ST_DISCARD;
            end else begin
              state_d = ST_PAY;
            end
          end else if (s_axis_tlast) begin
            inc_drop_bad = (beat_q == 3'd4);
            state_d      = ST_IDLE;
          end
        end
        ST_PAY: begin
          if (s_axis_tkeep[1:0] != 2'b11) begin
            inc_drop_bad = 1'b1;
          end else if (fifo_pciecfg_i_full) begin
            inc_drop_full = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            din_d      = entry;
            inc_accept = 1'b1;
          end
          state_d = s_axis_tlast ? ST_IDLE : ST_DISCARD;
        end
        ST_DISCARD: begin
          if (s_axis_tlast) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= 3'd0;
      src_ip_q   <= '0;
      src_port_q <= '0;
      is_write_q <= 1'b0;
      be_q       <= '0;
      pos_q      <= '0;
      data_hi_q  <= '0;
      wr_en_q    <= 1'b0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      is_write_q <= is_write_d;
      be_q       <= be_d;
      pos_q      <= pos_d;
      data_hi_q  <= data_hi_d;
      wr_en_q    <= wr_en_d;
      din_q      <= din_d;
    end
  end

  assign fifo_pciecfg_i_wr_en = wr_en_q;
  assign fifo_pciecfg_i_din   = din_q;
  assign dbg_state            = state_q;

  pciecfg_rx_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .inc_accept     (inc_accept),
    .inc_drop_full  (inc_drop_full),
    .inc_drop_bad   (inc_drop_bad),
    .stat_accept    (stat_accept),
    .stat_drop_full (stat_drop_full),
    .stat_drop_bad  (stat_drop_bad)
  );

endmodule

// File: tb/tb_pciecfg_rx.sv
// Bench for pciecfg_rx: frames are built as byte arrays, a byte-offset model
// predicts each frame's fate, and a negedge process checks every write.
module tb_pciecfg_rx;
  import pciecfg_pkg::*;

  localparam int EW = $bits(FIFO_PCIECFG_T);
`ifdef PCIECFG_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [31:0] LOCAL_IP = 32'h0A00_0001;
  localparam int O_SILENT = 0, O_BAD = 1, O_FULL = 2, O_ACC = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] local_ip = LOCAL_IP;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic fifo_pciecfg_i_wr_en, fifo_pciecfg_i_full = 1'b0;
  FIFO_PCIECFG_T fifo_pciecfg_i_din;
  logic [31:0] stat_accept, stat_drop_full, stat_drop_bad;
  pciecfg_rx_state_e dbg_state;

  always #5 clk = ~clk;

  pciecfg_rx dut (
    .clk                  (clk),
    .rst                  (rst),
    .local_ip             (local_ip),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tlast         (s_axis_tlast),
    .fifo_pciecfg_i_wr_en (fifo_pciecfg_i_wr_en),
    .fifo_pciecfg_i_full  (fifo_pciecfg_i_full),
    .fifo_pciecfg_i_din   (fifo_pciecfg_i_din),
    .stat_accept          (stat_accept),
    .stat_drop_full       (stat_drop_full),
    .stat_drop_bad        (stat_drop_bad),
    .dbg_state            (dbg_state)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [EW-1:0] last_din = '0;
  int exp_accept = 0, exp_full = 0, exp_bad = 0;
  logic [7:0] fb [0:95];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      last_din = '0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      if (fifo_pciecfg_i_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_en_unexpected", fifo_pciecfg_i_wr_en, 1'b0);
        end else begin
          chk("wr_cycle", cyc, exp_cyc_q[0]);
          chk("wr_din", fifo_pciecfg_i_din, exp_q[0]);
          last_din = exp_q.pop_front();
          void'(exp_cyc_q.pop_front());
        end
      end else begin
        if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
          chk("wr_en_missed", fifo_pciecfg_i_wr_en, 1'b1);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
        chk("din_hold", fifo_pciecfg_i_din, last_din);
      end
      chk("tready", s_axis_tready, 1'b1);
    end
  end

  // ---------------- frame building and model ----------------
  task automatic put16(input int off, input logic [15:0] v);
    fb[off] = v[15:8]; fb[off+1] = v[7:0];
  endtask

  task automatic put32(input int off, input logic [31:0] v);
    put16(off, v[31:16]); put16(off + 2, v[15:0]);
  endtask

  task automatic build(input logic [31:0] dip, input logic [7:0] opc, input logic [7:0] be,
                       input logic [15:0] addr, input logic [31:0] data,
                       input logic [31:0] sip, input logic [15:0] sport);
    for (int i = 0; i < 96; i++) fb[i] = 8'($urandom);
    put16(12, 16'h0800);
    fb[14] = 8'h45;
    fb[23] = 8'h11;
    put32(26, sip);
    put32(30, dip);
    put16(34, sport);
    put16(36, 16'h3000);
    fb[42] = opc;
    fb[43] = be;
    put16(44, addr);
    put32(46, data);
  endtask

  // Fate of a frame from its bytes: header must be complete and match;
  // then the payload must be whole (bytes up to offset 49) and well formed.
  task automatic model(input int len, input bit full_v, output int outc, output logic [EW-1:0] ent);
    FIFO_PCIECFG_T e;
    logic [15:0] addr;
    int nb;
    e = '0;
    outc = O_SILENT;
    nb = (len + 7) / 8;
    addr = {fb[44], fb[45]};
    if (nb >= 5 && {fb[12], fb[13]} == 16'h0800 && fb[14] == 8'h45 && fb[23] == 8'h11 &&
        {fb[30], fb[31], fb[32], fb[33]} == LOCAL_IP && {fb[36], fb[37]} == 16'h3000) begin
      if (len < 50 || fb[42] > 8'h01 || addr[15:12] != 4'h0) outc = O_BAD;
      else if (full_v) outc = O_FULL;
      else begin
        outc       = O_ACC;
        e.is_write = (fb[42] == 8'h01);
        e.be       = fb[43][3:0];
        e.pos      = addr[11:2];
        e.data     = e.is_write ? {fb[46], fb[47], fb[48], fb[49]} : 32'h0;
        e.src_ip   = {fb[26], fb[27], fb[28], fb[29]};
        e.src_port = {fb[34], fb[35]};
      end
    end
    ent = e;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tdata  = {$urandom, $urandom};
      fifo_pciecfg_i_full = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int len, input bit full_v, input int gap_beat, input int gap_len);
    int nb, rem, outc;
    logic [EW-1:0] ent;
    model(len, full_v, outc, ent);
    case (outc)
      O_BAD:   exp_bad++;
      O_FULL:  exp_full++;
      O_ACC:   exp_accept++;
      default: ;
    endcase
    nb  = (len + 7) / 8;
    rem = len % 8;
    for (int b = 0; b < nb; b++) begin
      if (b == gap_beat) idle(gap_len);
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 8; i++) s_axis_tdata[8*i +: 8] = fb[8*b + i];
      s_axis_tlast = (b == nb - 1);
      s_axis_tkeep = (b == nb - 1 && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      fifo_pciecfg_i_full = (b == 6) ? full_v : 1'($urandom_range(0, 1));
      if (b == 6 && outc == O_ACC) begin
        exp_q.push_back(ent);
        exp_cyc_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_lit(input string tag, input int a, input int f, input int b);
    idle(2);
    @(negedge clk);
    chk({tag, "_accept"}, stat_accept, STATS ? a : 0);
    chk({tag, "_drop_full"}, stat_drop_full, STATS ? f : 0);
    chk({tag, "_drop_bad"}, stat_drop_bad, STATS ? b : 0);
    @(posedge clk); #1;
  endtask

  FIFO_PCIECFG_T lit;

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_tready", s_axis_tready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_wr_en", fifo_pciecfg_i_wr_en, 1'b0);
    chk("reset_din", fifo_pciecfg_i_din, '0);
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_accept", stat_accept, 32'd0);
    chk("reset_drop_full", stat_drop_full, 32'd0);
    chk("reset_drop_bad", stat_drop_bad, 32'd0);
    @(posedge clk); #1;

    // Plain write: 01 0F 00 10 DE AD BE EF
    build(LOCAL_IP, 8'h01, 8'h0F, 16'h0010, 32'hDEADBEEF, 32'h0A00_0063, 16'h1234);
    send_frame(64, 1'b0, -1, 0);
    check_lit("t1", 1, 0, 0);
    lit = '{is_write: 1'b1, be: 4'hF, pos: 10'd4, data: 32'hDEADBEEF,
            src_ip: 32'h0A00_0063, src_port: 16'h1234};
    chk("t1_din_literal", fifo_pciecfg_i_din, lit);

    // Read to another host
    build(32'h0A00_0002, 8'h00, 8'h0F, 16'h0010, 32'h0, 32'h0A00_0063, 16'h1234);
    send_frame(64, 1'b0, -1, 0);
    check_lit("t2", 1, 0, 0);

    // Read while full, then the same frame with room
    build(LOCAL_IP, 8'h00, 8'hF3, 16'h0125, 32'h1111_2222, 32'hC0A8_0105, 16'hBEEF);
    send_frame(64, 1'b1, -1, 0);
    check_lit("t3_full", 1, 1, 0);
    send_frame(64, 1'b0, -1, 0);
    check_lit("t3_retry", 2, 1, 0);
    lit = '{is_write: 1'b0, be: 4'h3, pos: 10'h049, data: 32'h0,
            src_ip: 32'hC0A8_0105, src_port: 16'hBEEF};
    chk("t3_din_literal", fifo_pciecfg_i_din, lit);

    // Bad opcode, truncated after the port, then a good frame
    build(LOCAL_IP, 8'h07, 8'h0F, 16'h0010, 32'h0, 32'h0A00_0063, 16'h1234);
    send_frame(64, 1'b0, -1, 0);
    check_lit("t4_opcode", 2, 1, 1);
    build(LOCAL_IP, 8'h01, 8'h0F, 16'h0010, 32'h0, 32'h0A00_0063, 16'h1234);
    send_frame(40, 1'b0, -1, 0);
    check_lit("t4_trunc", 2, 1, 2);
    build(LOCAL_IP, 8'h01, 8'h05, 16'h0ABC, 32'hCAFE_F00D, 32'h0A00_0007, 16'h0042);
    send_frame(56, 1'b0, -1, 0);
    check_lit("t4_after", 3, 1, 2);

    // Back-to-back frames, second with a 3-cycle gap
    build(LOCAL_IP, 8'h01, 8'h0C, 16'h0FFC, 32'h0102_0304, 32'h0A00_0010, 16'h1000);
    send_frame(56, 1'b0, -1, 0);
    build(LOCAL_IP, 8'h00, 8'h01, 16'h0004, 32'h0, 32'h0A00_0011, 16'h1001);
    send_frame(64, 1'b0, 3, 3);
    check_lit("t5", 5, 1, 2);

    // Reset on beat 3 of a valid frame
    build(LOCAL_IP, 8'h01, 8'h0F, 16'h0020, 32'h5555_AAAA, 32'h0A00_0063, 16'h1234);
    for (int b = 0; b < 4; b++) begin
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 8; i++) s_axis_tdata[8*i +: 8] = fb[8*b + i];
      s_axis_tkeep = 8'hFF;
      s_axis_tlast = 1'b0;
      if (b == 3) rst = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_accept = 0; exp_full = 0; exp_bad = 0;
    @(negedge clk);
    chk("t6_state", dbg_state, ST_IDLE);
    chk("t6_din", fifo_pciecfg_i_din, '0);
    @(posedge clk); #1;
    check_lit("t6_reset", 0, 0, 0);
    send_frame(64, 1'b0, -1, 0);
    check_lit("t6_after", 1, 0, 0);

    // Randomized frames
    for (int f = 0; f < 200; f++) begin
      int mode, len, gap_beat;
      bit full_v;
      mode = $urandom_range(0, 11);
      build(LOCAL_IP, 8'($urandom_range(0, 1)), 8'($urandom), {4'h0, 12'($urandom)},
            $urandom, $urandom, 16'($urandom));
      case (mode)
        0: fb[12 + $urandom_range(0, 1)] ^= 8'h01;
        1: fb[14] = 8'h46;
        2: fb[23] = 8'h06;
        3: fb[30 + $urandom_range(0, 3)] ^= 8'h80;
        4: fb[36 + $urandom_range(0, 1)] ^= 8'h01;
        5: fb[42] = 8'($urandom_range(2, 255));
        6: fb[44][7:4] = 4'($urandom_range(1, 15));
        default: ;
      endcase
      len      = ($urandom_range(0, 9) < 7) ? $urandom_range(50, 80) : $urandom_range(1, 80);
      full_v   = ($urandom_range(0, 3) == 0);
      gap_beat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
      send_frame(len, full_v, gap_beat, $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    check_lit("random", exp_accept, exp_full, exp_bad);
    idle(2);
    chk("pending_writes", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
